// File: rtl/tnn_neuron_feeder.sv
// Serial front end for a combinational five-operand TNN neuron core: packs 3-bit
// beats into op_a..op_e, samples the core decision once, returns it over valid/ready.
module tnn_neuron_feeder #(
    parameter int OPW  = 3,
    parameter int NOPS = 5,
    parameter int CNTW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [OPW-1:0]  i_in_data,
    input  logic            i_in_sof,
    output logic [OPW-1:0]  o_op_a,
    output logic [OPW-1:0]  o_op_b,
    output logic [OPW-1:0]  o_op_c,
    output logic [OPW-1:0]  o_op_d,
    output logic [OPW-1:0]  o_op_e,
    input  logic            i_core_out,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic            o_out_bit,
    output logic            o_frame_err,
    output logic [CNTW-1:0] o_frame_cnt
);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_EVAL    = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    localparam int              IDXW     = $clog2(NOPS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NOPS - 1);

    logic [1:0]      r_state;
    logic [IDXW-1:0] r_idx;
    logic [OPW-1:0]  r_ops [NOPS];
    logic            r_outBit;
    logic            r_frameErr;
    logic [CNTW-1:0] r_frameCnt;

    logic w_beatTaken;
    logic w_handshake;

    assign w_beatTaken = i_in_valid && (r_state == S_COLLECT);
    assign w_handshake = i_out_ready && (r_state == S_RESP);

    // A sof beat always restarts the frame; a non-sof beat with no frame open is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_COLLECT;
            r_idx      <= '0;
            r_frameErr <= 1'b0;
        end else begin
            r_frameErr <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_beatTaken) begin
                        if (i_in_sof) begin
                            r_idx      <= IDXW'(1);
                            r_frameErr <= (r_idx != '0);
                        end else if (r_idx == '0) begin
                            r_frameErr <= 1'b1;
                        end else if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= S_EVAL;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (i_out_ready) begin
                        r_state <= S_COLLECT;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NOPS; i++) begin
                r_ops[i] <= '0;
            end
        end else if (w_beatTaken) begin
            if (i_in_sof) begin
                r_ops[0] <= i_in_data;
            end else if (r_idx != '0) begin
                r_ops[r_idx] <= i_in_data;
            end
        end
    end

    // The operands have been stable for the whole EVAL cycle, so the core output has settled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_outBit <= 1'b0;
        end else if (r_state == S_EVAL) begin
            r_outBit <= i_core_out;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frameCnt <= '0;
        end else if (w_handshake) begin
            r_frameCnt <= r_frameCnt + 1'b1;
        end
    end

    assign o_in_ready  = (r_state == S_COLLECT);
    assign o_out_valid = (r_state == S_RESP);
    assign o_out_bit   = r_outBit;
    assign o_frame_err = r_frameErr;
    assign o_frame_cnt = r_frameCnt;
    assign o_op_a      = r_ops[0];
    assign o_op_b      = r_ops[1];
    assign o_op_c      = r_ops[2];
    assign o_op_d      = r_ops[3];
    assign o_op_e      = r_ops[4];

endmodule

// File: tb/tb_tnn_neuron_feeder.sv
// Randomized bench for tnn_neuron_feeder; a frame-level reference model predicts
// operands, error pulses, decisions and the result count.
module tb_tnn_neuron_feeder;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [2:0]  inData;
    logic        inSof;
    logic [2:0]  opA, opB, opC, opD, opE;
    logic        coreOut;
    logic        outValid;
    logic        outReady;
    logic        outBit;
    logic        frameErr;
    logic [15:0] frameCnt;

    int testsRun    = 0;
    int testsFailed = 0;

    int          mFrame[$];
    logic [2:0]  mOps[5];
    logic [15:0] mCnt;
    bit          mBit;

    always #5 clk = ~clk;

    // External neuron core: fires when a outweighs the sum of the other four operands.
    assign coreOut = ({3'b000, opA} > ({3'b000, opB} + {3'b000, opC} + {3'b000, opD} + {3'b000, opE}));

    tnn_neuron_feeder #(.OPW(3), .NOPS(5), .CNTW(16)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_in_valid(inValid), .o_in_ready(inReady), .i_in_data(inData), .i_in_sof(inSof),
        .o_op_a(opA), .o_op_b(opB), .o_op_c(opC), .o_op_d(opD), .o_op_e(opE),
        .i_core_out(coreOut),
        .o_out_valid(outValid), .i_out_ready(outReady), .o_out_bit(outBit),
        .o_frame_err(frameErr), .o_frame_cnt(frameCnt)
    );

    function automatic bit decide(input int a, input int b, input int c, input int d, input int e);
        return a > (b + c + d + e);
    endfunction

    task automatic modelReset();
        mFrame.delete();
        mCnt = '0;
        mBit = 1'b0;
        for (int i = 0; i < 5; i++) mOps[i] = '0;
    endtask

    task automatic modelBeat(input int d, input bit sof, output bit err, output bit done);
        err  = 1'b0;
        done = 1'b0;
        if (sof) begin
            err = (mFrame.size() != 0);
            mFrame.delete();
            mFrame.push_back(d);
            mOps[0] = 3'(d);
        end else if (mFrame.size() == 0) begin
            err = 1'b1;
        end else begin
            mOps[mFrame.size()] = 3'(d);
            mFrame.push_back(d);
            if (mFrame.size() == 5) begin
                done = 1'b1;
                mBit = decide(mFrame[0], mFrame[1], mFrame[2], mFrame[3], mFrame[4]);
                mFrame.delete();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        inValid  = 1'b0;
        inSof    = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        rstN     = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
        modelReset();
    endtask

    task automatic waitReady(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (inReady !== 1'b1) begin
            if (n >= 50) begin
                ok = 1'b0;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic waitResult(output bit ok, output int cycles);
        cycles = 0;
        ok     = 1'b1;
        while (outValid !== 1'b1) begin
            if (cycles >= 50) begin
                ok = 1'b0;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    // Presents one beat once in_ready is up; returns the frame_err seen after the accepting edge.
    task automatic sendBeat(input int d, input bit sof, output bit errSeen, output bit errExp, output bit done);
        bit ok;
        waitReady(ok);
        if (!ok) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL in_ready_timeout: got %0b expected 1", inReady);
        end
        modelBeat(d, sof, errExp, done);
        inValid = 1'b1;
        inData  = 3'(d);
        inSof   = sof;
        tick();
        inValid = 1'b0;
        inSof   = 1'b0;
        errSeen = frameErr;
    endtask

    task automatic handshake();
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        mCnt = mCnt + 16'd1;
    endtask

    task automatic test_reset();
        inValid  = 1'b0;
        inSof    = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        rstN     = 1'b1;
        #1 rstN  = 1'b0;
        #2;
        testsRun++;
        if (inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", inReady); end
        testsRun++;
        if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", outValid); end
        tick();
        tick();
        testsRun++;
        if ({opA, opB, opC, opD, opE} !== 15'd0) begin testsFailed++; $display("[TB] FAIL reset_ops: got %0h expected 0", {opA, opB, opC, opD, opE}); end
        testsRun++;
        if ({outBit, frameErr} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_bit_err: got %0b expected 0", {outBit, frameErr}); end
        testsRun++;
        if (frameCnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frameCnt); end
        rstN = 1'b1;
        modelReset();
    endtask

    task automatic test_clean_frame();
        int  vals[5] = '{5, 1, 0, 2, 1};
        bit  errSeen, errExp, done, ok;
        int  cycles;
        for (int i = 0; i < 5; i++) begin
            sendBeat(vals[i], i == 0, errSeen, errExp, done);
            testsRun++;
            if (errSeen !== errExp) begin testsFailed++; $display("[TB] FAIL clean_err: got %0b expected %0b", errSeen, errExp); end
        end
        testsRun++;
        if ({opA, opB, opC, opD, opE} !== {mOps[0], mOps[1], mOps[2], mOps[3], mOps[4]}) begin
            testsFailed++;
            $display("[TB] FAIL clean_ops: got %0h expected %0h", {opA, opB, opC, opD, opE}, {mOps[0], mOps[1], mOps[2], mOps[3], mOps[4]});
        end
        testsRun++;
        if ({inReady, outValid} !== 2'b00) begin testsFailed++; $display("[TB] FAIL clean_eval_phase: got %0b expected 00", {inReady, outValid}); end
        waitResult(ok, cycles);
        testsRun++;
        if (!ok || cycles != 1) begin testsFailed++; $display("[TB] FAIL clean_latency: got %0d expected 1", cycles); end
        testsRun++;
        if (outBit !== mBit) begin testsFailed++; $display("[TB] FAIL clean_out_bit: got %0b expected %0b", outBit, mBit); end
        tick();
        testsRun++;
        if ({outValid, outBit} !== {1'b1, mBit}) begin testsFailed++; $display("[TB] FAIL clean_hold: got %0b expected %0b", {outValid, outBit}, {1'b1, mBit}); end
        handshake();
        testsRun++;
        if (frameCnt !== mCnt) begin testsFailed++; $display("[TB] FAIL clean_frame_cnt: got %0d expected %0d", frameCnt, mCnt); end
        testsRun++;
        if ({inReady, outValid} !== 2'b10) begin testsFailed++; $display("[TB] FAIL clean_after_hs: got %0b expected 10", {inReady, outValid}); end
    endtask

    task automatic test_back_to_back();
        int data[10][5];
        bit expBits[10];
        bit err, done;
        int pos, f;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 5; j++) data[i][j] = int'($urandom_range(0, 7));
            expBits[i] = decide(data[i][0], data[i][1], data[i][2], data[i][3], data[i][4]);
        end
        inValid  = 1'b1;
        outReady = 1'b1;
        for (int k = 0; k < 70; k++) begin
            pos = k % 7;
            f   = k / 7;
            if (pos < 5) begin
                inData = 3'(data[f][pos]);
                inSof  = (pos == 0);
                modelBeat(data[f][pos], pos == 0, err, done);
            end else begin
                inData = 3'($urandom_range(0, 7));
                inSof  = 1'b0;
            end
            testsRun++;
            if (inReady !== (pos < 5)) begin testsFailed++; $display("[TB] FAIL b2b_in_ready cycle %0d: got %0b expected %0b", k, inReady, pos < 5); end
            testsRun++;
            if (outValid !== (pos == 6)) begin testsFailed++; $display("[TB] FAIL b2b_out_valid cycle %0d: got %0b expected %0b", k, outValid, pos == 6); end
            testsRun++;
            if (frameErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_frame_err cycle %0d: got %0b expected 0", k, frameErr); end
            if (pos == 6) begin
                testsRun++;
                if (outBit !== expBits[f]) begin testsFailed++; $display("[TB] FAIL b2b_out_bit frame %0d: got %0b expected %0b", f, outBit, expBits[f]); end
            end
            tick();
        end
        inValid  = 1'b0;
        inSof    = 1'b0;
        outReady = 1'b0;
        mCnt = mCnt + 16'd10;
        testsRun++;
        if (frameCnt !== mCnt) begin testsFailed++; $display("[TB] FAIL b2b_frame_cnt: got %0d expected %0d", frameCnt, mCnt); end
    endtask

    task automatic test_resync();
        int  vals[7] = '{3, 2, 7, 0, 0, 0, 0};
        bit  sofs[7] = '{1, 0, 1, 0, 0, 0, 0};
        bit  errSeen, errExp, done, ok;
        int  errCount, cycles, extra;
        errCount = 0;
        for (int i = 0; i < 7; i++) begin
            sendBeat(vals[i], sofs[i], errSeen, errExp, done);
            errCount += int'(errSeen);
            testsRun++;
            if (errSeen !== errExp) begin testsFailed++; $display("[TB] FAIL resync_err beat %0d: got %0b expected %0b", i, errSeen, errExp); end
        end
        testsRun++;
        if (errCount != 1) begin testsFailed++; $display("[TB] FAIL resync_err_count: got %0d expected 1", errCount); end
        testsRun++;
        if ({opA, opB, opC, opD, opE} !== {mOps[0], mOps[1], mOps[2], mOps[3], mOps[4]}) begin
            testsFailed++;
            $display("[TB] FAIL resync_ops: got %0h expected %0h", {opA, opB, opC, opD, opE}, {mOps[0], mOps[1], mOps[2], mOps[3], mOps[4]});
        end
        waitResult(ok, cycles);
        testsRun++;
        if (!ok || outBit !== mBit) begin testsFailed++; $display("[TB] FAIL resync_out_bit: got %0b expected %0b", outBit, mBit); end
        handshake();
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            extra += int'(outValid === 1'b1);
            tick();
        end
        testsRun++;
        if (extra != 0) begin testsFailed++; $display("[TB] FAIL resync_single_result: got %0d expected 0", extra); end
        testsRun++;
        if (frameCnt !== mCnt) begin testsFailed++; $display("[TB] FAIL resync_frame_cnt: got %0d expected %0d", frameCnt, mCnt); end
    endtask

    task automatic test_backpressure();
        bit errSeen, errExp, done, ok;
        int cycles;
        for (int i = 0; i < 5; i++) begin
            sendBeat(int'($urandom_range(0, 7)), i == 0, errSeen, errExp, done);
        end
        waitResult(ok, cycles);
        testsRun++;
        if (!ok) begin testsFailed++; $display("[TB] FAIL bp_result_timeout: got 0 expected 1"); end
        inValid  = 1'b1;
        inSof    = 1'b1;
        inData   = 3'd6;
        outReady = 1'b0;
        for (int k = 0; k < 20; k++) begin
            testsRun++;
            if ({outValid, outBit, inReady} !== {1'b1, mBit, 1'b0}) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold cycle %0d: got %0b expected %0b", k, {outValid, outBit, inReady}, {1'b1, mBit, 1'b0});
            end
            tick();
        end
        inValid = 1'b0;
        inSof   = 1'b0;
        handshake();
        testsRun++;
        if ({opA, opB, opC, opD, opE} !== {mOps[0], mOps[1], mOps[2], mOps[3], mOps[4]}) begin
            testsFailed++;
            $display("[TB] FAIL bp_no_consume: got %0h expected %0h", {opA, opB, opC, opD, opE}, {mOps[0], mOps[1], mOps[2], mOps[3], mOps[4]});
        end
        testsRun++;
        if ({frameCnt, inReady, outValid} !== {mCnt, 2'b10}) begin
            testsFailed++;
            $display("[TB] FAIL bp_complete: got %0h expected %0h", {frameCnt, inReady, outValid}, {mCnt, 2'b10});
        end
    endtask

    task automatic test_random();
        bit errSeen, errExp, done, ok, sof;
        int cycles, delay;
        for (int n = 0; n < 80; n++) begin
            if (mFrame.size() == 0) sof = ($urandom_range(0, 9) != 0);
            else                    sof = ($urandom_range(0, 9) == 0);
            sendBeat(int'($urandom_range(0, 7)), sof, errSeen, errExp, done);
            testsRun++;
            if (errSeen !== errExp) begin testsFailed++; $display("[TB] FAIL rand_err beat %0d: got %0b expected %0b", n, errSeen, errExp); end
            testsRun++;
            if ({opA, opB, opC, opD, opE} !== {mOps[0], mOps[1], mOps[2], mOps[3], mOps[4]}) begin
                testsFailed++;
                $display("[TB] FAIL rand_ops beat %0d: got %0h expected %0h", n, {opA, opB, opC, opD, opE}, {mOps[0], mOps[1], mOps[2], mOps[3], mOps[4]});
            end
            if (done) begin
                waitResult(ok, cycles);
                testsRun++;
                if (!ok || cycles != 1) begin testsFailed++; $display("[TB] FAIL rand_latency: got %0d expected 1", cycles); end
                delay = int'($urandom_range(0, 3));
                repeat (delay) tick();
                testsRun++;
                if ({outValid, outBit} !== {1'b1, mBit}) begin testsFailed++; $display("[TB] FAIL rand_result: got %0b expected %0b", {outValid, outBit}, {1'b1, mBit}); end
                handshake();
                testsRun++;
                if (frameCnt !== mCnt) begin testsFailed++; $display("[TB] FAIL rand_frame_cnt: got %0d expected %0d", frameCnt, mCnt); end
            end
        end
    endtask

    task automatic test_stray_beat();
        bit errSeen, errExp, done, ok;
        int cycles;
        applyReset();
        sendBeat(4, 1'b0, errSeen, errExp, done);
        testsRun++;
        if (errSeen !== errExp) begin testsFailed++; $display("[TB] FAIL stray_err: got %0b expected %0b", errSeen, errExp); end
        testsRun++;
        if (opA !== mOps[0]) begin testsFailed++; $display("[TB] FAIL stray_dropped: got %0d expected %0d", opA, mOps[0]); end
        for (int i = 0; i < 5; i++) begin
            sendBeat(int'($urandom_range(0, 7)), i == 0, errSeen, errExp, done);
            testsRun++;
            if (errSeen !== errExp) begin testsFailed++; $display("[TB] FAIL stray_frame_err: got %0b expected %0b", errSeen, errExp); end
        end
        testsRun++;
        if (opA !== mOps[0]) begin testsFailed++; $display("[TB] FAIL stray_op_a: got %0d expected %0d", opA, mOps[0]); end
        waitResult(ok, cycles);
        testsRun++;
        if (!ok || outBit !== mBit) begin testsFailed++; $display("[TB] FAIL stray_out_bit: got %0b expected %0b", outBit, mBit); end
        handshake();
        testsRun++;
        if (frameCnt !== mCnt) begin testsFailed++; $display("[TB] FAIL stray_frame_cnt: got %0d expected %0d", frameCnt, mCnt); end
    endtask

    task automatic test_reset_mid();
        bit errSeen, errExp, done, ok;
        int cycles;
        for (int i = 0; i < 3; i++) sendBeat(int'($urandom_range(1, 7)), i == 0, errSeen, errExp, done);
        rstN = 1'b0;
        #2;
        modelReset();
        testsRun++;
        if ({inReady, outValid, outBit, frameErr, frameCnt} !== {4'b1000, mCnt}) begin
            testsFailed++;
            $display("[TB] FAIL midreset_collect: got %0h expected %0h", {inReady, outValid, outBit, frameErr, frameCnt}, {4'b1000, mCnt});
        end
        testsRun++;
        if ({opA, opB, opC, opD, opE} !== 15'd0) begin testsFailed++; $display("[TB] FAIL midreset_ops: got %0h expected 0", {opA, opB, opC, opD, opE}); end
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) sendBeat(int'($urandom_range(0, 7)), i == 0, errSeen, errExp, done);
        waitResult(ok, cycles);
        testsRun++;
        if (!ok) begin testsFailed++; $display("[TB] FAIL midreset_resp_timeout: got 0 expected 1"); end
        rstN = 1'b0;
        #2;
        modelReset();
        testsRun++;
        if ({inReady, outValid, outBit, frameCnt} !== {3'b100, mCnt}) begin
            testsFailed++;
            $display("[TB] FAIL respreset: got %0h expected %0h", {inReady, outValid, outBit, frameCnt}, {3'b100, mCnt});
        end
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) sendBeat(int'($urandom_range(0, 7)), i == 0, errSeen, errExp, done);
        waitResult(ok, cycles);
        testsRun++;
        if (!ok || outBit !== mBit) begin testsFailed++; $display("[TB] FAIL postreset_out_bit: got %0b expected %0b", outBit, mBit); end
        handshake();
        testsRun++;
        if (frameCnt !== mCnt) begin testsFailed++; $display("[TB] FAIL postreset_frame_cnt: got %0d expected %0d", frameCnt, mCnt); end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_resync();
        test_backpressure();
        test_random();
        test_stray_beat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
